fp16_add_engine: RTL
====================

Name: fp16_add_engine

Overview:
Hardware responder for the float-addition start/done protocol.
- A requester (bench or control block) loads two IEEE-754 half-precision operands into the 8-bit data memory, pulses `start`, then waits for `done`.
- On start release, the engine fetches both operands byte-by-byte, adds them, and writes the 16-bit result back to memory.
- It then asserts `done` and holds it until the next request.
- Sits beside the data memory as a memory-port master; the requester reads the result directly from memory.

Parameters:
- `AW`, 8, data-memory address width
- `A_ADDR`, 4, address of operand A low byte (high byte at `A_ADDR+1`)
- `B_ADDR`, 2, address of operand B low byte (high byte at `B_ADDR+1`)
- `R_ADDR`, 6, address of result low byte (high byte at `R_ADDR+1`)

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — synchronous, active-low; 0 = reset
- `start` in 1 — request; rise arms the engine, fall launches the operation
- `done` out 1 — result written; level, held until next `start`=1
- `mem_addr` out AW — data-memory address
- `mem_rdata` in 8 — data-memory read data, combinational read of `mem_addr`
- `mem_we` out 1 — write enable, write occurs on rising edge
- `mem_wdata` out 8 — write data

Behaviour:
- Reset (`reset`=0 at a clock edge): FSM→IDLE; `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Reset mid-operation abandons the operation immediately: no further memory writes, and partial results are discarded.
- FSM states: IDLE, ARMED, RD_AL, RD_AH, RD_BL, RD_BH, ALIGN, ADD, NORM, WR_L, WR_H, DONE.
- IDLE/DONE: `start`=1 → ARMED, and `done` clears in the same edge.
- ARMED: `start`=0 → RD_AL; wait while `start`=1.
- RD_*: one cycle each. Drive `mem_addr` to `A_ADDR`, `A_ADDR+1`, `B_ADDR`, `B_ADDR+1` in that order, and capture `mem_rdata` at the end of each cycle.
- Unpacking: sign = bit15; exp = bits14:10; mant11 = {|exp, bits9:0}. Exponent 0 gives hidden bit 0; no further denormal handling. No Inf/NaN input decoding.
- ALIGN: order the operands by {exp, mant}, larger first. Shift the smaller mant right by the exponent difference (truncate); a difference ≥12 makes it 0. Result exp = larger exp; result sign = larger's sign.
- ADD: equal signs → 12-bit sum; otherwise larger − smaller.
  - Carry-out (bit11=1): shift right 1, exp+1.
  - Difference exactly 0: result forced to 0x0000; skip NORM.
- NORM: one left shift per cycle, exp−1, while bit10=0 and exp>1.
  - Maximum 10 cycles.
  - If still unnormalized at exp=1, store with exp field 0 (denormal form).
- Overflow: exp ≥31 after ADD → result {sign, 5'h1F, 10'h000}.
- WR_L: `mem_addr`=`R_ADDR`, `mem_wdata`=result[7:0], `mem_we`=1.
- WR_H: `mem_addr`=`R_ADDR+1`, `mem_wdata`=result[15:8], `mem_we`=1.
- `mem_we`=0 in every other state.
- DONE: `done`=1.
- Latency from the first cycle with `start`=0 in ARMED to `done`=1: 9 + N cycles, where N = NORM cycles (0..10).
- Boundary cases:
  - `start` reasserted during RD..WR: ignored; the operation completes, then DONE sees `start`=1 → ARMED.
  - `start` held low forever after DONE: stays in DONE with `done`=1.
  - R region overlapping A or B: legal; all reads complete before any write.

Optional Feature:
- Macro: `FP16_ADD_RND_EN`.
- Defined: ALIGN keeps guard, round and sticky bits; the right shift in ADD feeds the guard bit. After NORM, round to nearest, ties to even. A rounding carry renormalizes (shift right, exp+1) and can trigger overflow to Inf. Adds at most one cycle (RND state).
- Undefined: pure truncation, no RND state.

Test Plan:
- 0x1A04 + 0x1A04 → 0x1E04 at mem[7:6]; `done` 9 cycles after start release; `mem_we` pulses exactly 2 cycles.
- 0x4204 + 0x4204 → 0x4604. 0x3C00 + 0x0C00 (exponent gap 12) → 0x3C00.
- 0x3C00 + 0xB800 → 0x3800 (one NORM cycle, latency 10). 0x4500 + 0xC500 → 0x0000.
- 0x7BFF + 0x7BFF → 0x7C00. 0x3C03 + 0x3C00 → 0x4001 without `FP16_ADD_RND_EN`, 0x4002 with it.
- Reset (`reset`=0) asserted in NORM → `done`=0 and no memory write; mem[7:6] keeps its prior value. Next start/release computes correctly.
- Two back-to-back requests with `start` raised while `done`=1 → `done` drops on the next edge, the second result overwrites the first, and `done` returns after the same latency.

Source files
------------

// File: rtl/fp16_add_engine.sv
// fp16_add_engine: start/done responder that fetches two FP16 operands from an
// 8-bit data memory, adds them and writes the 16-bit result back.
// Optional build macro: FP16_ADD_RND_EN (guard/round/sticky plus round-to-nearest-even).
// Ports:
//   clk       - clock, all state on rising edge
//   reset     - synchronous, active-low
//   start     - request: rise arms, fall launches
//   done      - result written, held until next start=1
//   mem_addr  - data-memory address
//   mem_rdata - data-memory read data (combinational read of mem_addr)
//   mem_we    - data-memory write enable
//   mem_wdata - data-memory write data
module fp16_add_engine #(
    parameter int unsigned AW     = 8,
    parameter int unsigned A_ADDR = 4,
    parameter int unsigned B_ADDR = 2,
    parameter int unsigned R_ADDR = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [7:0]    mem_wdata
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ARMED = 4'd1;
    localparam logic [3:0] S_RD_AL = 4'd2;
    localparam logic [3:0] S_RD_AH = 4'd3;
    localparam logic [3:0] S_RD_BL = 4'd4;
    localparam logic [3:0] S_RD_BH = 4'd5;
    localparam logic [3:0] S_ALIGN = 4'd6;
    localparam logic [3:0] S_ADD   = 4'd7;
    localparam logic [3:0] S_NORM  = 4'd8;
    localparam logic [3:0] S_WR_L  = 4'd9;
    localparam logic [3:0] S_WR_H  = 4'd10;
    localparam logic [3:0] S_DONE  = 4'd11;
`ifdef FP16_ADD_RND_EN
    localparam logic [3:0]  S_RND    = 4'd12;
    localparam logic [3:0]  S_POST   = S_RND;
    localparam logic [13:0] LOW_MASK = 14'h3FFF;
`else
    localparam logic [3:0]  S_POST   = S_WR_L;
    // Truncating build: the aligned operand loses everything below its LSB.
    localparam logic [13:0] LOW_MASK = 14'h3FF8;
`endif

    // Working mantissa: 11 significant bits at [13:3], guard/round/sticky at [2:0].
    logic [3:0]  state, state_n;
    logic [15:0] op_a, op_a_n, op_b, op_b_n;
    logic        sign_r, sign_n, sub_r, sub_n, zero_r, zero_n;
    logic [5:0]  exp_r, exp_n;
    logic [13:0] big_m, big_n, sml_m, sml_n, w_r, w_n;
    logic        done_n, mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [7:0]  mem_wdata_n;
    logic [15:0] res_n;

    logic [4:0]  ea, eb, e_hi, e_lo, diff;
    logic [10:0] ma, mb, m_hi, m_lo;
    logic        a_big;
    logic [27:0] ext;
    logic [14:0] sum;
`ifdef FP16_ADD_RND_EN
    logic        rnd_up;
    logic [11:0] mant_rnd;
`endif

    // Final FP16 encoding of a working result.
    function automatic logic [15:0] pack(input logic s, input logic [5:0] e,
                                         input logic [13:0] w, input logic z);
        logic [4:0] ef;
        ef = w[13] ? ((e == 6'd0) ? 5'd1 : e[4:0]) : 5'd0;
        if (z)                pack = 16'h0000;
        else if (e >= 6'd31)  pack = {s, 5'h1F, 10'h000};
        else                  pack = {s, ef, w[12:3]};
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_a      <= 16'h0000;
            op_b      <= 16'h0000;
            sign_r    <= 1'b0;
            sub_r     <= 1'b0;
            zero_r    <= 1'b0;
            exp_r     <= 6'd0;
            big_m     <= 14'd0;
            sml_m     <= 14'd0;
            w_r       <= 14'd0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            state     <= state_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            sign_r    <= sign_n;
            sub_r     <= sub_n;
            zero_r    <= zero_n;
            exp_r     <= exp_n;
            big_m     <= big_n;
            sml_m     <= sml_n;
            w_r       <= w_n;
            done      <= done_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    // Next state, datapath and registered-output values.
    always_comb begin
        state_n = state;
        op_a_n  = op_a;
        op_b_n  = op_b;
        sign_n  = sign_r;
        sub_n   = sub_r;
        zero_n  = zero_r;
        exp_n   = exp_r;
        big_n   = big_m;
        sml_n   = sml_m;
        w_n     = w_r;

        ea    = op_a[14:10];
        eb    = op_b[14:10];
        ma    = {|ea, op_a[9:0]};
        mb    = {|eb, op_b[9:0]};
        a_big = {ea, ma} >= {eb, mb};
        e_hi  = a_big ? ea : eb;
        e_lo  = a_big ? eb : ea;
        m_hi  = a_big ? ma : mb;
        m_lo  = a_big ? mb : ma;
        diff  = e_hi - e_lo;
        ext   = {m_lo, 3'b000, 14'd0} >> diff;
        sum   = sub_r ? ({1'b0, big_m} - {1'b0, sml_m}) : ({1'b0, big_m} + {1'b0, sml_m});
`ifdef FP16_ADD_RND_EN
        rnd_up   = w_r[2] & (w_r[1] | w_r[0] | w_r[3]);
        mant_rnd = {1'b0, w_r[13:3]} + {11'd0, rnd_up};
`endif

        case (state)
            S_IDLE, S_DONE: if (start) state_n = S_ARMED;
            S_ARMED:        if (!start) state_n = S_RD_AL;
            S_RD_AL: begin op_a_n[7:0]  = mem_rdata; state_n = S_RD_AH; end
            S_RD_AH: begin op_a_n[15:8] = mem_rdata; state_n = S_RD_BL; end
            S_RD_BL: begin op_b_n[7:0]  = mem_rdata; state_n = S_RD_BH; end
            S_RD_BH: begin op_b_n[15:8] = mem_rdata; state_n = S_ALIGN; end
            S_ALIGN: begin
                sign_n  = a_big ? op_a[15] : op_b[15];
                sub_n   = op_a[15] ^ op_b[15];
                exp_n   = {1'b0, e_hi};
                big_n   = {m_hi, 3'b000};
                // Bits shifted past the sticky position are ORed into it.
                sml_n   = {ext[27:15], ext[14] | (|ext[13:0])} & LOW_MASK;
                state_n = S_ADD;
            end
            S_ADD: begin
                zero_n = sub_r && (sum == 15'd0);
                if (sum[14]) begin
                    w_n   = {sum[14:2], sum[1] | sum[0]};
                    exp_n = exp_r + 6'd1;
                end else begin
                    w_n   = sum[13:0];
                end
                if (!zero_n && !w_n[13] && exp_n > 6'd1 && exp_n < 6'd31)
                    state_n = S_NORM;
                else
                    state_n = S_POST;
            end
            S_NORM: begin
                w_n   = w_r << 1;
                exp_n = exp_r - 6'd1;
                // Stop once bit10 is set or the exponent reaches 1.
                if (w_r[12] || exp_r <= 6'd2) state_n = S_POST;
            end
`ifdef FP16_ADD_RND_EN
            S_RND: begin
                if (mant_rnd[11]) begin
                    w_n   = {mant_rnd[11:1], 3'b000};
                    exp_n = exp_r + 6'd1;
                end else begin
                    w_n   = {mant_rnd[10:0], 3'b000};
                end
                state_n = S_WR_L;
            end
`endif
            S_WR_L:  state_n = S_WR_H;
            S_WR_H:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase

        res_n       = pack(sign_n, exp_n, w_n, zero_n);
        done_n      = (state_n == S_DONE);
        mem_we_n    = (state_n == S_WR_L) || (state_n == S_WR_H);
        mem_addr_n  = '0;
        mem_wdata_n = 8'h00;
        case (state_n)
            S_RD_AL: mem_addr_n = AW'(A_ADDR);
            S_RD_AH: mem_addr_n = AW'(A_ADDR + 1);
            S_RD_BL: mem_addr_n = AW'(B_ADDR);
            S_RD_BH: mem_addr_n = AW'(B_ADDR + 1);
            S_WR_L:  begin mem_addr_n = AW'(R_ADDR);     mem_wdata_n = res_n[7:0];  end
            S_WR_H:  begin mem_addr_n = AW'(R_ADDR + 1); mem_wdata_n = res_n[15:8]; end
            default: ;
        endcase
    end

endmodule
